// File: rtl/output_stage.sv
// output_stage: back end of the DDSM sliced pipeline.
// Realigns the skewed LSB/ISB/MSB slices (and the MSB carry) into one word
// with a matching valid. It also keeps a sticky overflow flag and a wrapping
// count of emitted samples for the quantiser / output register bank.
//
// Timing, in enabled cycles: the LSB and valid of a sample are captured
// first. The ISB arrives one enabled cycle later. The MSB and carry arrive
// two enabled cycles later and go straight into the output register.
// i_en stalls every register in lock step with the upstream skew stage, so
// the slice relationship survives stalls.

module output_stage #(
  parameter int P_SLICE_W = 8,
  parameter int P_CNT_W   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_vld,
  input  logic [P_SLICE_W-1:0]     i_lsb,
  input  logic [P_SLICE_W-1:0]     i_isb,
  input  logic [P_SLICE_W-1:0]     i_msb,
  input  logic                     i_carry,
  input  logic                     i_clr_ovf,
  output logic                     o_vld,
  output logic [3*P_SLICE_W-1:0]   o_data,
  output logic                     o_carry,
  output logic                     o_ovf,
  output logic [P_CNT_W-1:0]       o_cnt
);

  // Skew-compensation delay lines.
  logic [P_SLICE_W-1:0]   r_lsb_d1;
  logic [P_SLICE_W-1:0]   r_lsb_d2;
  logic [P_SLICE_W-1:0]   r_isb_d1;
  logic                   r_vld_d1;
  logic                   r_vld_d2;

  // Output register bank.
  logic [3*P_SLICE_W-1:0] r_data;
  logic                   r_carry;
  logic                   r_vld;
  logic                   r_ovf;
  logic [P_CNT_W-1:0]     r_cnt;

  // An aligned valid sample is being registered to the output this edge.
  logic                   w_emit;
  // That sample also carried out of the MSB slice.
  logic                   w_set_ovf;

  assign w_emit    = i_en & r_vld_d2;
  assign w_set_ovf = w_emit & i_carry;

  // Delay lines: LSB and valid two stages deep, ISB one stage deep; hold on stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lsb_d1 <= {P_SLICE_W{1'b0}};
      r_lsb_d2 <= {P_SLICE_W{1'b0}};
      r_isb_d1 <= {P_SLICE_W{1'b0}};
      r_vld_d1 <= 1'b0;
      r_vld_d2 <= 1'b0;
    end else if (i_en) begin
      r_lsb_d1 <= i_lsb;
      r_lsb_d2 <= r_lsb_d1;
      r_isb_d1 <= i_isb;
      r_vld_d1 <= i_vld;
      r_vld_d2 <= r_vld_d1;
    end else begin
      r_lsb_d1 <= r_lsb_d1;
      r_lsb_d2 <= r_lsb_d2;
      r_isb_d1 <= r_isb_d1;
      r_vld_d1 <= r_vld_d1;
      r_vld_d2 <= r_vld_d2;
    end
  end

  // Aligned output word, carry and valid; refreshed every enabled cycle regardless of valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= {(3*P_SLICE_W){1'b0}};
      r_carry <= 1'b0;
      r_vld   <= 1'b0;
    end else if (i_en) begin
      r_data  <= {i_msb, r_isb_d1, r_lsb_d2};
      r_carry <= i_carry;
      r_vld   <= r_vld_d2;
    end else begin
      r_data  <= r_data;
      r_carry <= r_carry;
      r_vld   <= r_vld;
    end
  end

  // Emitted-sample counter; wraps silently at 2^P_CNT_W.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {P_CNT_W{1'b0}};
    end else if (w_emit) begin
      r_cnt <= r_cnt + {{(P_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Sticky overflow: a set wins over a clear in the same cycle; the clear works even while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_set_ovf) begin
      r_ovf <= 1'b1;
    end else if (i_clr_ovf) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign o_vld   = r_vld;
  assign o_data  = r_data;
  assign o_carry = r_carry;
  assign o_ovf   = r_ovf;
  assign o_cnt   = r_cnt;

endmodule

// File: tb/tb_output_stage.sv
// Testbench for output_stage.
// The reference model is sample oriented. The bench keeps a list of samples
// indexed by enabled cycle. It drives each slice with its skew, and it
// expects sample n to be emitted at the edge of enabled cycle n+2. A second
// instance with a 4-bit counter runs in parallel to exercise the wrap.

module tb_output_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_en, i_vld, i_carry, i_clr_ovf;
  logic [7:0]  i_lsb, i_isb, i_msb;

  logic        o_vld, o_carry, o_ovf;
  logic [23:0] o_data;
  logic [15:0] o_cnt;

  logic        o4_vld, o4_carry, o4_ovf;
  logic [23:0] o4_data;
  logic [3:0]  o4_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Sample stream, indexed by enabled cycle.
  logic [23:0] s_word [0:63];
  bit          s_vld  [0:63];
  bit          s_car  [0:63];
  int          j;

  // Expected output state.
  logic        e_vld, e_car, e_ovf;
  logic [23:0] e_data;
  logic [15:0] e_cnt;

  always #5 i_clk = ~i_clk;

  output_stage #(.P_SLICE_W(8), .P_CNT_W(16)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_vld(i_vld),
    .i_lsb(i_lsb), .i_isb(i_isb), .i_msb(i_msb), .i_carry(i_carry),
    .i_clr_ovf(i_clr_ovf), .o_vld(o_vld), .o_data(o_data),
    .o_carry(o_carry), .o_ovf(o_ovf), .o_cnt(o_cnt)
  );

  output_stage #(.P_SLICE_W(8), .P_CNT_W(4)) u_dut4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_vld(i_vld),
    .i_lsb(i_lsb), .i_isb(i_isb), .i_msb(i_msb), .i_carry(i_carry),
    .i_clr_ovf(i_clr_ovf), .o_vld(o4_vld), .o_data(o4_data),
    .o_carry(o4_carry), .o_ovf(o4_ovf), .o_cnt(o4_cnt)
  );

  task automatic garbage_inputs();
    i_vld   = 1'($urandom);
    i_carry = 1'($urandom);
    i_lsb   = 8'($urandom);
    i_isb   = 8'($urandom);
    i_msb   = 8'($urandom);
  endtask

  task automatic clear_stream();
    for (int i = 0; i < 64; i++) begin
      s_word[i] = 24'h000000;
      s_vld[i]  = 1'b0;
      s_car[i]  = 1'b0;
    end
  endtask

  // Assert reset with garbage inputs, reset the model, release after one edge.
  task automatic do_reset();
    i_rst_n = 1'b0;
    garbage_inputs();
    i_en = 1'($urandom);
    i_clr_ovf = 1'($urandom);
    e_vld = 1'b0; e_car = 1'b0; e_ovf = 1'b0; e_data = 24'h000000; e_cnt = 16'h0000;
    j = 0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  // Drive one cycle from the sample stream (or garbage when stalled) and advance the model.
  task automatic feed(input bit en, input bit clr);
    if (en) begin
      i_vld   = s_vld[j];
      i_lsb   = s_word[j][7:0];
      i_isb   = (j >= 1) ? s_word[j-1][15:8]  : 8'h00;
      i_msb   = (j >= 2) ? s_word[j-2][23:16] : 8'h00;
      i_carry = (j >= 2) ? s_car[j-2]         : 1'b0;
    end else begin
      garbage_inputs();
    end
    i_en      = en;
    i_clr_ovf = clr;
    @(posedge i_clk); #1;
    if (en) begin
      if (j >= 2) begin
        e_vld = s_vld[j-2]; e_data = s_word[j-2]; e_car = s_car[j-2];
      end else begin
        e_vld = 1'b0; e_data = 24'h000000; e_car = 1'b0;
      end
      if (e_vld) e_cnt = e_cnt + 16'd1;
      j++;
    end
    if (en && e_vld && e_car) e_ovf = 1'b1;
    else if (clr) e_ovf = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    garbage_inputs();
    i_en = 1'b1; i_clr_ovf = 1'b0;
    #2;
    n_cmp++;
    if ({o_vld, o_data, o_cnt, o_ovf, o4_cnt} !== 46'd0) begin
      n_err++;
      $display("FAIL reset_initial: got vld=%b data=%h cnt=%h ovf=%b cnt4=%h, want all 0",
               o_vld, o_data, o_cnt, o_ovf, o4_cnt);
    end
    do_reset();
    // Stream carry=1 valid samples, then reset mid-flight between edges.
    clear_stream();
    for (int i = 0; i < 8; i++) begin
      s_word[i] = 24'($urandom); s_vld[i] = 1'b1; s_car[i] = 1'b1;
    end
    for (int c = 0; c < 5; c++) feed(1'b1, 1'b0);
    i_rst_n = 1'b0;
    garbage_inputs();
    #1;
    n_cmp++;
    if ({o_vld, o_data, o_cnt, o_ovf, o4_cnt} !== 46'd0) begin
      n_err++;
      $display("FAIL reset_mid: got vld=%b data=%h cnt=%h ovf=%b cnt4=%h, want all 0",
               o_vld, o_data, o_cnt, o_ovf, o4_cnt);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    e_vld = 1'b0; e_car = 1'b0; e_ovf = 1'b0; e_data = 24'h000000; e_cnt = 16'h0000;
    j = 0;
  endtask

  task automatic test_single();
    do_reset();
    clear_stream();
    s_word[0] = 24'h332211; s_vld[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      feed(1'b1, 1'b0);
      n_cmp++;
      if ({o_vld, o_carry, o_ovf, o_cnt, o_data, o4_vld, o4_carry, o4_ovf, o4_cnt, o4_data} !==
          {e_vld, e_car, e_ovf, e_cnt, e_data, e_vld, e_car, e_ovf, e_cnt[3:0], e_data}) begin
        n_err++;
        $display("FAIL single c=%0d: got vld=%b data=%h cnt=%h ovf=%b cnt4=%h, want vld=%b data=%h cnt=%h ovf=%b",
                 c, o_vld, o_data, o_cnt, o_ovf, o4_cnt, e_vld, e_data, e_cnt, e_ovf);
      end
      if (c == 2) begin
        n_cmp++;
        if ({o_vld, o_data, o_cnt, o_ovf} !== {1'b1, 24'h332211, 16'd1, 1'b0}) begin
          n_err++;
          $display("FAIL single_emit: got vld=%b data=%h cnt=%0d ovf=%b, want 1 332211 1 0",
                   o_vld, o_data, o_cnt, o_ovf);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (o_vld !== 1'b0) begin
          n_err++;
          $display("FAIL single_pulse: got vld=%b, want 0", o_vld);
        end
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    clear_stream();
    for (int i = 0; i < 5; i++) begin
      s_word[i] = 24'(i + 1); s_vld[i] = 1'b1;
    end
    for (int c = 0; c < 9; c++) begin
      feed(1'b1, 1'b0);
      n_cmp++;
      if ({o_vld, o_carry, o_ovf, o_cnt, o_data, o4_vld, o4_carry, o4_ovf, o4_cnt, o4_data} !==
          {e_vld, e_car, e_ovf, e_cnt, e_data, e_vld, e_car, e_ovf, e_cnt[3:0], e_data}) begin
        n_err++;
        $display("FAIL stream c=%0d: got vld=%b data=%h cnt=%h, want vld=%b data=%h cnt=%h",
                 c, o_vld, o_data, o_cnt, e_vld, e_data, e_cnt);
      end
    end
    n_cmp++;
    if (o_cnt !== 16'd5) begin
      n_err++;
      $display("FAIL stream_count: got %0d, want 5", o_cnt);
    end
  endtask

  task automatic test_stall();
    bit en_pat [0:8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    clear_stream();
    s_word[0] = 24'h332211; s_vld[0] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      feed(en_pat[c], 1'b0);
      n_cmp++;
      if ({o_vld, o_carry, o_ovf, o_cnt, o_data, o4_vld, o4_carry, o4_ovf, o4_cnt, o4_data} !==
          {e_vld, e_car, e_ovf, e_cnt, e_data, e_vld, e_car, e_ovf, e_cnt[3:0], e_data}) begin
        n_err++;
        $display("FAIL stall c=%0d: got vld=%b data=%h cnt=%h, want vld=%b data=%h cnt=%h",
                 c, o_vld, o_data, o_cnt, e_vld, e_data, e_cnt);
      end
      if (c == 3 || c == 6 || c == 8) begin
        n_cmp++;
        if ({o_vld, o_cnt} !== ((c == 3) ? {1'b0, 16'd0} : (c == 6) ? {1'b1, 16'd1} : {1'b0, 16'd1})) begin
          n_err++;
          $display("FAIL stall_hold c=%0d: got vld=%b cnt=%0d", c, o_vld, o_cnt);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if ({o_vld, o_data} !== {1'b1, 24'h332211}) begin
          n_err++;
          $display("FAIL stall_emit: got vld=%b data=%h, want 1 332211", o_vld, o_data);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit en_pat  [0:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bit clr_pat [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit ovf_exp [0:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    clear_stream();
    s_word[0] = 24'hA5A5A5; s_vld[0] = 1'b1; s_car[0] = 1'b1;
    s_word[1] = 24'h5A5A5A; s_vld[1] = 1'b1; s_car[1] = 1'b1;
    s_word[2] = 24'h123456; s_vld[2] = 1'b0; s_car[2] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      feed(en_pat[c], clr_pat[c]);
      n_cmp++;
      if ({o_vld, o_carry, o_ovf, o_cnt, o_data, o4_vld, o4_carry, o4_ovf, o4_cnt, o4_data} !==
          {e_vld, e_car, e_ovf, e_cnt, e_data, e_vld, e_car, e_ovf, e_cnt[3:0], e_data}) begin
        n_err++;
        $display("FAIL overflow c=%0d: got vld=%b car=%b ovf=%b cnt=%h, want vld=%b car=%b ovf=%b cnt=%h",
                 c, o_vld, o_carry, o_ovf, o_cnt, e_vld, e_car, e_ovf, e_cnt);
      end
      n_cmp++;
      if (o_ovf !== ovf_exp[c]) begin
        n_err++;
        $display("FAIL overflow_flag c=%0d: got %b, want %b", c, o_ovf, ovf_exp[c]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    clear_stream();
    for (int i = 0; i < 17; i++) begin
      s_word[i] = 24'($urandom); s_vld[i] = 1'b1;
    end
    for (int c = 0; c < 19; c++) begin
      feed(1'b1, 1'b0);
      n_cmp++;
      if ({o_vld, o_carry, o_ovf, o_cnt, o_data, o4_vld, o4_carry, o4_ovf, o4_cnt, o4_data} !==
          {e_vld, e_car, e_ovf, e_cnt, e_data, e_vld, e_car, e_ovf, e_cnt[3:0], e_data}) begin
        n_err++;
        $display("FAIL wrap c=%0d: got cnt=%h cnt4=%h data=%h, want cnt=%h data=%h",
                 c, o_cnt, o4_cnt, o_data, e_cnt, e_data);
      end
      if (c >= 16) begin
        n_cmp++;
        if (o4_cnt !== ((c == 16) ? 4'd15 : (c == 17) ? 4'd0 : 4'd1)) begin
          n_err++;
          $display("FAIL wrap_cnt4 c=%0d: got %0d", c, o4_cnt);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      s_word[i] = 24'($urandom);
      s_vld[i]  = 1'($urandom);
      s_car[i]  = 1'($urandom);
    end
    for (int c = 0; c < 60; c++) begin
      feed(($urandom_range(3, 0) != 0), ($urandom_range(9, 0) == 0));
      n_cmp++;
      if ({o_vld, o_carry, o_ovf, o_cnt, o_data, o4_vld, o4_carry, o4_ovf, o4_cnt, o4_data} !==
          {e_vld, e_car, e_ovf, e_cnt, e_data, e_vld, e_car, e_ovf, e_cnt[3:0], e_data}) begin
        n_err++;
        $display("FAIL random c=%0d: got vld=%b car=%b ovf=%b cnt=%h data=%h, want vld=%b car=%b ovf=%b cnt=%h data=%h",
                 c, o_vld, o_carry, o_ovf, o_cnt, o_data, e_vld, e_car, e_ovf, e_cnt, e_data);
      end
    end
  endtask

  initial begin
    j = 0;
    test_reset();
    test_single();
    test_stream();
    test_stall();
    test_overflow();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
